// File: rtl/voting_result_announcer.sv
// voting_result_announcer: latches vote counts on the voting-over rising edge,
// resolves winner/tie, and sends the results as a UART 8N1 frame.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   i_voting_over   - voting closed level; its rising edge triggers a frame
//   i_count1..3     - candidate totals (COUNT_W bits each)
//   o_tx            - serial line, LSB first, idles high
//   o_busy          - high from trigger until the last stop bit ends
//   o_done          - frame complete, held until i_voting_over drops
//   o_winner, o_tie - resolved result, held until next trigger or reset
// Build option: define VOTE_CHECKSUM_EN to append an XOR checksum byte.
module voting_result_announcer #(
    parameter int COUNT_W      = 6,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_voting_over,
    input  logic [COUNT_W-1:0] i_count1,
    input  logic [COUNT_W-1:0] i_count2,
    input  logic [COUNT_W-1:0] i_count3,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_done,
    output logic [1:0]         o_winner,
    output logic               o_tie
);
    typedef enum logic [2:0] {IDLE, CALC, START, DATA, STOP, DONE} state_t;
`ifdef VOTE_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd5;
`else
    localparam logic [2:0] LAST_IDX = 3'd4;
`endif
    state_t state_q, state_d;
    logic hist_q, tx_q, tx_d, busy_q, busy_d, done_q, done_d, tie_q, tie_d;
    logic [1:0] win_q, win_d;
    logic [COUNT_W-1:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic [7:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d, idx_q, idx_d;
    logic [7:0] status, byte_c;
    logic trig, last_baud, u1, u2, u3;

    assign trig      = state_q == IDLE && i_voting_over && !hist_q;
    assign last_baud = baud_q == 8'(CLKS_PER_BIT - 1);
    assign u1        = c1_q > c2_q && c1_q > c3_q;
    assign u2        = c2_q > c1_q && c2_q > c3_q;
    assign u3        = c3_q > c1_q && c3_q > c2_q;
    assign status    = {5'b0, tie_q, win_q};
`ifdef VOTE_CHECKSUM_EN
    logic [7:0] chk;
    assign chk    = 8'hA5 ^ 8'(c1_q) ^ 8'(c2_q) ^ 8'(c3_q) ^ status;
    assign byte_c = idx_q == 3'd0 ? 8'hA5 : idx_q == 3'd1 ? 8'(c1_q) :
                    idx_q == 3'd2 ? 8'(c2_q) : idx_q == 3'd3 ? 8'(c3_q) :
                    idx_q == 3'd4 ? status : chk;
`else
    assign byte_c = idx_q == 3'd0 ? 8'hA5 : idx_q == 3'd1 ? 8'(c1_q) :
                    idx_q == 3'd2 ? 8'(c2_q) : idx_q == 3'd3 ? 8'(c3_q) : status;
`endif
    // o_tx is registered from the current state, so the line lags the
    // state machine by one cycle (start bit appears two edges after trigger)
    assign tx_d = state_q == START ? 1'b0 : state_q == DATA ? byte_c[bit_q] : 1'b1;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = done_q;
        win_d   = win_q;
        tie_d   = tie_q;
        c1_d    = trig ? i_count1 : c1_q;
        c2_d    = trig ? i_count2 : c2_q;
        c3_d    = trig ? i_count3 : c3_q;
        baud_d  = (state_q == START || state_q == DATA || state_q == STOP) ?
                  (last_baud ? 8'd0 : baud_q + 8'd1) : 8'd0;
        bit_d   = bit_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (trig) begin
                state_d = CALC;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                bit_d   = 3'd0;
                idx_d   = 3'd0;
            end
            CALC: begin
                win_d   = u1 ? 2'd1 : u2 ? 2'd2 : u3 ? 2'd3 : 2'd0;
                tie_d   = !(u1 || u2 || u3) && (c1_q != '0 || c2_q != '0 || c3_q != '0);
                state_d = START;
            end
            START: state_d = last_baud ? DATA : START;
            DATA: if (last_baud) begin
                bit_d   = bit_q + 3'd1;
                state_d = bit_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (last_baud) begin
                state_d = idx_q == LAST_IDX ? DONE : START;
                idx_d   = idx_q == LAST_IDX ? idx_q : idx_q + 3'd1;
            end
            DONE: begin
                // first DONE cycle lets the final stop bit finish on the line
                busy_d  = done_q ? busy_q : 1'b0;
                done_d  = !done_q || i_voting_over;
                state_d = done_q && !i_voting_over ? IDLE : DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hist_q  <= 1'b1;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            win_q   <= 2'd0;
            tie_q   <= 1'b0;
            c1_q    <= '0;
            c2_q    <= '0;
            c3_q    <= '0;
            baud_q  <= 8'd0;
            bit_q   <= 3'd0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            hist_q  <= i_voting_over;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            win_q   <= win_d;
            tie_q   <= tie_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            c3_q    <= c3_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
        end
    end

    assign o_tx     = tx_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_winner = win_q;
    assign o_tie    = tie_q;
endmodule

// File: tb/tb_voting_result_announcer.sv
// tb_voting_result_announcer: directed scoreboard bench decoding the serial frame.
module tb_voting_result_announcer;
    localparam int CPB = 4;
`ifdef VOTE_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif
    logic clk = 1'b0, rst = 1'b1, vo = 1'b0;
    logic [5:0] c1 = '0, c2 = '0, c3 = '0;
    logic tx, busy, done, tie;
    logic [1:0] win;
    int checks = 0, errors = 0;
    logic [7:0] q[$];
    logic [7:0] cs;

    voting_result_announcer #(.COUNT_W(6), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .i_voting_over(vo),
        .i_count1(c1), .i_count2(c2), .i_count3(c3),
        .o_tx(tx), .o_busy(busy), .o_done(done), .o_winner(win), .o_tie(tie)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        cs ^= b;
    endtask

    task automatic push_frame(input logic [7:0] a, b, c, st);
        cs = 8'h00;
        push(8'hA5); push(a); push(b); push(c); push(st);
`ifdef VOTE_CHECKSUM_EN
        push(cs);
`endif
    endtask

    // monitor: samples mid-bit, pops the scoreboard on every decoded byte
    bit act = 1'b0;
    int cnt = 0;
    logic [7:0] sh;
    always @(negedge clk) begin
        if (rst) act = 1'b0;
        else if (!act) begin
            if (!tx) begin act = 1'b1; cnt = 0; end
        end else begin
            cnt++;
            for (int k = 0; k < 8; k++) if (cnt == CPB*(k+1) + CPB/2) sh[k] = tx;
            if (cnt == CPB*9 + CPB/2) begin
                act = 1'b0;
                chk("stop_bit", int'(tx), 1);
                if (q.size() == 0) chk("unexpected_byte", int'(sh), -1);
                else chk("rx_byte", int'(sh), int'(q.pop_front()));
            end
        end
    end

    task automatic frame(input logic [5:0] a, b, c, input logic [1:0] ew, input logic et, input bit chg);
        int n, first, lows;
        c1 = a; c2 = b; c3 = c;
        push_frame({2'b0, a}, {2'b0, b}, {2'b0, c}, {5'b0, et, ew});
        vo = 1'b1;
        tick();
        chk("busy_at_trigger", int'(busy), 1);
        n = 0; first = -1;
        while (busy && n < 2000) begin
            tick();
            n++;
            if (!tx && first < 0) first = n;
            if (chg && n == 20) c1 = 6'd9;
        end
        chk("tx_first_low", first, 2);
        chk("busy_len", n, 2 + NB*10*CPB);
        chk("winner", int'(win), int'(ew));
        chk("tie", int'(tie), int'(et));
        chk("done_set", int'(done), 1);
        lows = 0;
        repeat (50) begin tick(); if (!tx || busy) lows++; end
        chk("no_retransmit", lows, 0);
        chk("done_held", int'(done), 1);
        vo = 1'b0;
        tick();
        chk("done_clear", int'(done), 0);
        tick();
    endtask

    initial begin
        int lows;
        vo = 1'b1;
        repeat (3) tick();
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_winner", int'(win), 0);
        chk("rst_tie", int'(tie), 0);
        rst = 1'b0;
        lows = 0;
        repeat (60) begin tick(); if (!tx || busy) lows++; end
        chk("no_trigger_high_at_release", lows, 0);
        vo = 1'b0;
        tick();
        frame(6'd5, 6'd2, 6'd1, 2'd1, 1'b0, 1'b1);
        frame(6'd3, 6'd3, 6'd2, 2'd0, 1'b1, 1'b0);
        frame(6'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0);
        frame(6'd1, 6'd2, 6'd7, 2'd3, 1'b0, 1'b0);
        frame(6'd4, 6'd9, 6'd9, 2'd0, 1'b1, 1'b0);
        frame(6'd0, 6'd6, 6'd1, 2'd2, 1'b0, 1'b0);
        // reset during the count2 byte
        c1 = 6'd5; c2 = 6'd2; c3 = 6'd1;
        push_frame(8'h05, 8'h02, 8'h01, 8'h01);
        vo = 1'b1;
        tick();
        repeat (90) tick();
        chk("mid_busy", int'(busy), 1);
        chk("mid_bytes_left", q.size(), NB - 2);
        rst = 1'b1;
        vo = 1'b0;
        tick();
        chk("midrst_tx", int'(tx), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_winner", int'(win), 0);
        q.delete();
        rst = 1'b0;
        lows = 0;
        repeat (20) begin tick(); if (!tx) lows++; end
        chk("no_resend_after_rst", lows, 0);
        frame(6'd5, 6'd2, 6'd1, 2'd1, 1'b0, 1'b0);
        frame(6'd5, 6'd2, 6'd1, 2'd1, 1'b0, 1'b0);
        repeat (5) tick();
        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
